dual_port_ram_pair_summer: RTL

//  Downstream consumer of the 64x16 dual-port async-read RAM. After a start pulse it scans mirrored address pairs:
//  (a, DEPTH-1-a) for a = 0..DEPTH/2-1. It drives both RAM read-address ports and adds the two words.

---
 rtl/dpram_defs.sv | 16 +
 rtl/dual_port_ram_pair_summer.sv | 111 +++++++++++
 2 files changed

// File: rtl/dpram_defs.sv
// Shared defaults for the 64x16 dual-port RAM and its pair-summer consumer,
// plus the scan FSM state encoding.
package dpram_defs;

  localparam int DPRAM_ADDR_W = 6;
  localparam int DPRAM_DATA_W = 16;
  localparam int DPRAM_DEPTH  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/dual_port_ram_pair_summer.sv
// Scans mirrored RAM address pairs (a, DEPTH-1-a) and streams their sums over valid/ready.
// Optional XOR checksum of accepted sums is built only when PAIR_SUM_CHECKSUM_EN is defined.
module dual_port_ram_pair_summer
  import dpram_defs::*;
#(
  parameter int ADDR_W = DPRAM_ADDR_W,
  parameter int DATA_W = DPRAM_DATA_W,
  parameter int DEPTH  = DPRAM_DEPTH
) (
  input  logic              clockPulse,
  input  logic              resetN,
  input  logic              start,
  output logic [ADDR_W-1:0] firstAddr,
  output logic [ADDR_W-1:0] secondAddr,
  input  logic [DATA_W-1:0] firstData,
  input  logic [DATA_W-1:0] secondData,
  output logic [DATA_W:0]   sumOut,
  output logic              sumValid,
  input  logic              sumReady,
  output logic              busy,
  output logic              done,
  output logic [DATA_W:0]   checksum
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH / 2 - 1);
  localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W:0]   pair_sum;
  logic              accept_start;
  logic              handshake;

  // Addresses follow only the registered index, so they cannot move while a sum is held.
  assign firstAddr  = idx;
  assign secondAddr = TOP_ADDR - idx;

  assign pair_sum     = {1'b0, firstData} + {1'b0, secondData};
  assign accept_start = (state == IDLE) && start;
  assign handshake    = (state == HOLD) && sumValid && sumReady;

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let one register see another's new value.
  always_ff @(posedge clockPulse or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      idx      <= '0;
      sumOut   <= '0;
      sumValid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          sumOut   <= pair_sum;
          sumValid <= 1'b1;
          state    <= HOLD;
        end
        HOLD: begin
          if (handshake) begin
            sumValid <= 1'b0;
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= SCAN;
            end
          end
        end
        DONE: begin
          // Index returns home so the idle address pair reads 0 / DEPTH-1.
          done  <= 1'b0;
          busy  <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PAIR_SUM_CHECKSUM_EN
  logic [DATA_W:0] checksum_q;

  always_ff @(posedge clockPulse or negedge resetN) begin
    if (!resetN) begin
      checksum_q <= '0;
    end else if (accept_start) begin
      checksum_q <= '0;
    end else if (handshake) begin
      checksum_q <= checksum_q ^ sumOut;
    end
  end

  assign checksum = checksum_q;
`else
  logic unused_ck;
  assign unused_ck = accept_start;
  assign checksum  = '0;
`endif

endmodule
